// File: rtl/cam_pkg.sv
// Shared definitions for the CAM host-command front end: opcodes, FSM states,
// status bit positions and default field widths.
package cam_pkg;

  localparam int KEY_W_DEF  = 8;
  localparam int VAL_W_DEF  = 8;
  localparam int ADDR_W_DEF = 3;

  // Opcode carried in header byte bits [7:6]
  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SEARCH = 2'b10,
    OP_CLEAR  = 2'b11
  } cam_op_e;

  // Command assembly / issue state machine
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_KEY,
    ST_GET_VAL,
    ST_ISSUE,
    ST_WAIT_RSP
  } fe_state_e;

  // Bit positions inside the status byte; [2:0] carry the entry index
  localparam int STAT_BUSY = 7;
  localparam int STAT_HIT  = 6;
  localparam int STAT_ERR  = 5;
  localparam int STAT_TOUT = 4;
  localparam int STAT_DONE = 3;

endpackage

// File: rtl/cam_strobe_sync.sv
// Toggle-strobe receiver: brings the asynchronous host strobe into clk with a
// two-flop synchronizer, detects either edge, and captures the host byte,
// presenting it with a one-cycle byte_stb pulse.
module cam_strobe_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pin_data,
  input  logic       pin_strobe,
  output logic       byte_stb,
  output logic [7:0] byte_data
);

  logic sync1;
  logic sync2;
  logic prev;
  logic strobe_edge;

  // Two-flop synchronizer followed by the previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pin_strobe;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Any change of the synchronized level is one host byte
  assign strobe_edge = sync2 ^ prev;

  // Capture the byte on the detected edge and raise a single-cycle pulse with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_stb  <= 1'b0;
      byte_data <= 8'h00;
    end else begin
      byte_stb <= strobe_edge;
      if (strobe_edge) begin
        byte_data <= pin_data;
      end
    end
  end

endmodule

// File: rtl/cam_cmd_frontend.sv
// Host-command front end for the CAM core. Assembles WRITE/SEARCH/CLEAR
// commands from strobed host bytes, issues them over valid/ready and latches
// the CAM response into the status/result pins.
// Optional response watchdog: define CAM_CMD_TIMEOUT_EN.
module cam_cmd_frontend
  import cam_pkg::*;
#(
  parameter int KEY_W       = KEY_W_DEF,
  parameter int VAL_W       = VAL_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pin_data,
  input  logic              pin_strobe,
  output logic              cam_valid,
  input  logic              cam_ready,
  output logic [1:0]        cam_op,
  output logic [ADDR_W-1:0] cam_addr,
  output logic [KEY_W-1:0]  cam_key,
  output logic [VAL_W-1:0]  cam_value,
  input  logic              rsp_valid,
  input  logic              rsp_hit,
  input  logic [ADDR_W-1:0] rsp_index,
  input  logic [VAL_W-1:0]  rsp_value,
  output logic [7:0]        status,
  output logic [VAL_W-1:0]  result
);

  // Last WAIT_RSP cycle count before the watchdog fires (counter starts at 0)
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic        byte_stb;
  logic [7:0]  byte_data;
  cam_op_e     hdr_op;

  fe_state_e   state_reg;
  fe_state_e   state_next;

  cam_op_e           op_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [KEY_W-1:0]  key_reg;
  logic [VAL_W-1:0]  value_reg;
  logic              hit_reg;
  logic              err_reg;
  logic              tout_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] index_reg;
  logic [VAL_W-1:0]  result_reg;

  logic hdr_accept;
  logic key_load;
  logic val_load;
  logic rsp_take;
  logic tmo_fire;
  logic tmo_limit;
  logic busy;
  logic drop_byte;

  cam_strobe_sync u_strobe_sync (
    .clk        (clk),
    .rst        (rst),
    .pin_data   (pin_data),
    .pin_strobe (pin_strobe),
    .byte_stb   (byte_stb),
    .byte_data  (byte_data)
  );

  assign hdr_op    = cam_op_e'(byte_data[7:6]);
  assign busy      = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_RSP);
  // Bytes arriving while a command is in flight cannot be used
  assign drop_byte = byte_stb && busy;

`ifdef CAM_CMD_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;

  // Watchdog counts cycles spent in WAIT_RSP; held at zero everywhere else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= 8'd0;
    end else if (state_reg == ST_WAIT_RSP) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end else begin
      tmo_cnt_reg <= 8'd0;
    end
  end

  assign tmo_limit = (tmo_cnt_reg == TMO_LAST);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_LAST;
  assign tmo_limit      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and single-cycle datapath strobes
  always_comb begin
    state_next = state_reg;
    hdr_accept = 1'b0;
    key_load   = 1'b0;
    val_load   = 1'b0;
    rsp_take   = 1'b0;
    tmo_fire   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (byte_stb && (hdr_op != OP_NOP)) begin
          hdr_accept = 1'b1;
          state_next = (hdr_op == OP_CLEAR) ? ST_ISSUE : ST_GET_KEY;
        end
      end
      ST_GET_KEY: begin
        if (byte_stb) begin
          key_load   = 1'b1;
          state_next = (op_reg == OP_WRITE) ? ST_GET_VAL : ST_ISSUE;
        end
      end
      ST_GET_VAL: begin
        if (byte_stb) begin
          val_load   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // cam_valid is high throughout ISSUE, so ready alone completes the handshake
        if (cam_ready) begin
          state_next = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        // A response arriving in the watchdog's last cycle still wins
        if (rsp_valid) begin
          rsp_take   = 1'b1;
          state_next = ST_IDLE;
        end else if (tmo_limit) begin
          tmo_fire   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Command fields, sticky status flags and the result byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg     <= OP_NOP;
      addr_reg   <= '0;
      key_reg    <= '0;
      value_reg  <= '0;
      hit_reg    <= 1'b0;
      err_reg    <= 1'b0;
      tout_reg   <= 1'b0;
      done_reg   <= 1'b0;
      index_reg  <= '0;
      result_reg <= '0;
    end else begin
      if (hdr_accept) begin
        op_reg    <= hdr_op;
        // Only WRITE targets an entry; other ops present address 0
        addr_reg  <= (hdr_op == OP_WRITE) ? byte_data[ADDR_W-1:0] : '0;
        key_reg   <= '0;
        value_reg <= '0;
        err_reg   <= 1'b0;
        tout_reg  <= 1'b0;
        done_reg  <= 1'b0;
      end
      if (key_load) begin
        key_reg <= byte_data[KEY_W-1:0];
      end
      if (val_load) begin
        value_reg <= byte_data[VAL_W-1:0];
      end
      if (drop_byte) begin
        err_reg <= 1'b1;
      end
      if (rsp_take) begin
        done_reg <= 1'b1;
        if (op_reg == OP_SEARCH) begin
          hit_reg    <= rsp_hit;
          index_reg  <= rsp_index;
          result_reg <= rsp_hit ? rsp_value : '0;
        end else begin
          hit_reg   <= 1'b0;
          index_reg <= addr_reg;
        end
      end
      if (tmo_fire) begin
        tout_reg  <= 1'b1;
        err_reg   <= 1'b1;
        done_reg  <= 1'b1;
        hit_reg   <= 1'b0;
        index_reg <= '0;
      end
    end
  end

  assign cam_valid = (state_reg == ST_ISSUE);
  assign cam_op    = op_reg;
  assign cam_addr  = addr_reg;
  assign cam_key   = key_reg;
  assign cam_value = value_reg;
  assign status    = {busy, hit_reg, err_reg, tout_reg, done_reg, index_reg};
  assign result    = result_reg;

endmodule
